uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4, meaning the number of byte entries in the transmit FIFO; it is a power of two, 2..16.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port data_in, input, 8 bits: the byte to enqueue.
REQ-006 The module SHALL have port wr_en, input, 1 bit: enqueue request, sampled on each rising edge.
REQ-007 The module SHALL have port full, output, 1 bit: high when the FIFO holds FIFO_DEPTH entries.
REQ-008 The module SHALL have port level, output, clog2(FIFO_DEPTH)+1 bits: the current FIFO occupancy.
REQ-009 The module SHALL have port busy, output, 1 bit: high whenever a frame is in progress (any state other than IDLE).
REQ-010 The module SHALL have port txd, output, 1 bit: the serial line, 8N1 format, idle-high; top level connects it to UART_TXD.

Function
REQ-011 A write SHALL be accepted on a rising edge where wr_en=1 and full=0; data_in is stored at the tail and level increments.
REQ-012 When full=1, a write SHALL be ignored even if a pop occurs in the same cycle; the stored data and level are unchanged by the write.
REQ-013 When an accepted write and a pop occur in the same cycle, level SHALL be unchanged and both the head and tail pointers SHALL advance; pointers wrap modulo FIFO_DEPTH.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 In IDLE with level>0, the FSM SHALL pop the head byte into the shift register and move to START at the next edge; txd goes low on that same edge.
REQ-016 The latency from an accepted write into an empty FIFO with the FSM in IDLE to txd falling SHALL be exactly 1 clock.
REQ-017 START SHALL hold txd=0 for CLKS_PER_BIT cycles, then move to DATA.
REQ-018 DATA SHALL send 8 bits LSB first, each held for CLKS_PER_BIT cycles; a 3-bit index counts 0..7, then the FSM moves to STOP.
REQ-019 STOP SHALL hold txd=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-020 A frame SHALL occupy exactly 10*CLKS_PER_BIT cycles.
REQ-021 Back-to-back frames SHALL have exactly 1 idle cycle (txd=1, IDLE) between the end of STOP and the next start bit.
REQ-022 The baud counter SHALL count 0..CLKS_PER_BIT-1, clear on every state or bit transition, and be at least 16 bits wide.
REQ-023 txd SHALL be driven from a register, so it is glitch-free.
REQ-024 busy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-025 full SHALL equal (level==FIFO_DEPTH) combinationally from the registered level.
REQ-026 A write accepted during an active frame SHALL NOT alter the frame in progress.

Reset
REQ-027 While rst=0, the module SHALL set txd=1, busy=0, full=0, level=0, the FSM to IDLE, both pointers to 0, and all counters to 0.
REQ-028 Asserting rst mid-frame SHALL abort the frame immediately (asynchronously) with txd=1; queued bytes are discarded.
REQ-029 FIFO storage contents SHALL NOT require reset.
REQ-030 After rst deasserts, no frame SHALL start until a new write is accepted.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Single write of 0xA5 into an empty FIFO -> txd falls 1 clk after the write edge; line pattern per 4-clk bit is 0,1,0,1,0,0,1,0,1,1; busy high for 40 clks; level returns to 0.
REQ-032 Five consecutive writes 0x01..0x05 while idle -> the first is popped at once, the next 4 fill the FIFO (full=1, level=4); frames go out in order 01,02,03,04,05 with a 1-clk gap between each.
REQ-033 Write 0xFF while full=1 and the FSM not popping -> ignored; level stays 4; 0xFF never appears on txd.
REQ-034 Write coincident with a pop at level=2 -> level stays 2; byte order is preserved across pointer wrap (more than 4 total writes).
REQ-035 rst pulsed low at the 5th data bit of 0x3C with 2 bytes queued -> txd=1, busy=0, level=0 immediately; the line stays idle-high afterwards until a new write.
REQ-036 Write 0x00 -> txd low for 36 consecutive clks (start bit plus 8 data bits), then high for 4 clks.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter on an idle-high line.
// Latency: a write into an empty FIFO with the transmitter idle drops txd 1 clk later; a frame is 10*CLKS_PER_BIT clks.
// Backpressure: full=1 while FIFO_DEPTH bytes are queued; writes presented while full are dropped.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  data_in,
    input  logic                        wr_en,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        busy,
    output logic                        txd
);
    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          LVL_W     = PTR_W + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [15:0]      baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             txd_d;
    logic             wr_acc;
    logic             pop;

    // full is derived from the registered occupancy, so a write on a full cycle is dropped
    // even if the transmitter pops in the same cycle
    assign full   = (level == LVL_W'(FIFO_DEPTH));
    assign wr_acc = wr_en && !full;
    assign busy   = (state_q != IDLE);

    // FIFO storage: no reset, occupancy bookkeeping alone decides what is valid
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy; simultaneous write and pop leaves level unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc && !pop) begin
                level <= level + 1'b1;
            end else if (!wr_acc && pop) begin
                level <= level - 1'b1;
            end
        end
    end

    // Transmitter state, baud/bit counters, frame byte and registered line output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            txd     <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txd     <= txd_d;
        end
    end

    // Next-state logic: txd_d is the line value for the cycle after this edge, so the
    // start bit appears on the same edge that pops the head byte
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        txd_d   = txd;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                txd_d  = 1'b1;
                if (level != '0) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr];
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    txd_d   = shreg_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shreg_q[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed stimulus for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Expected bytes go into a queue when written; a line monitor decodes every frame and
// compares its full 40-sample waveform against the byte at the head of the queue.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       wr_en = 1'b0;
    logic       full;
    logic [2:0] level;
    logic       busy;
    logic       txd;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         frames_done = 0;
    int         wr_cyc = 0;
    logic [7:0] exp_q[$];
    int         start_log[$];

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en),
        .full(full), .level(level), .busy(busy), .txd(txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 ns, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Expected 40-sample line waveform: start, 8 data bits LSB first, stop; 4 samples each.
    function automatic logic [39:0] build_wave(input logic [7:0] b);
        logic [39:0] w;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       w[i] = 1'b0;
            else if (i < 36) w[i] = b[(i / 4) - 1];
            else             w[i] = 1'b1;
        end
        return w;
    endfunction

    // Called just after a negedge; presents one write for exactly one rising edge.
    task automatic wr_byte(input logic [7:0] d, input bit accept);
        data_in = d;
        wr_en   = 1'b1;
        if (accept) exp_q.push_back(d);
        @(negedge clk);
        wr_en   = 1'b0;
        wr_cyc  = cyc;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (frames_done < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (frames_done < n) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_timeout: got %0d frames, required %0d", frames_done, n);
        end
    endtask

    // Line monitor: sample at negedge, detect the start edge, capture 40 samples
    initial begin : monitor
        logic        prev;
        logic        have_exp;
        logic        aborted;
        logic        busy_ok;
        logic [7:0]  eb;
        logic [39:0] act;
        prev = 1'b1;
        eb   = 8'h00;
        forever begin
            @(negedge clk);
            if (rst && prev && !txd) begin
                start_log.push_back(cyc);
                have_exp = (exp_q.size() > 0);
                if (have_exp) eb = exp_q.pop_front();
                act     = '0;
                aborted = 1'b0;
                busy_ok = busy;
                act[0]  = txd;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clk);
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    act[i] = txd;
                    if (!busy) busy_ok = 1'b0;
                end
                if (!aborted) begin
                    if (!have_exp) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_frame: got line wave %h, required no frame", act);
                    end else begin
                        check($sformatf("frame_wave_%02h", eb), 64'(act), 64'(build_wave(eb)));
                        check("frame_busy", 64'(busy_ok), 64'd1);
                    end
                    frames_done++;
                end
                prev = aborted ? 1'b1 : act[39];
            end else begin
                prev = txd;
            end
        end
    end

    initial begin : stimulus
        int fd0;
        int t;
        logic line_ok;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_txd", 64'(txd), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_full", 64'(full), 64'd0);
        check("reset_level", 64'(level), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte 0xA5: 1-clk latency, full frame, FIFO drains
        start_log.delete();
        fd0 = frames_done;
        wr_byte(8'hA5, 1'b1);
        wait_frames(fd0 + 1, 100);
        if (start_log.size() > 0) check("a5_latency", 64'(start_log[0] - wr_cyc), 64'd1);
        else check("a5_latency", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
        check("a5_busy_after", 64'(busy), 64'd0);
        check("a5_level_after", 64'(level), 64'd0);

        // Five back-to-back writes, then a write while full
        start_log.delete();
        fd0 = frames_done;
        for (int i = 1; i <= 5; i++) wr_byte(8'(i), 1'b1);
        check("fill_level", 64'(level), 64'd4);
        check("fill_full", 64'(full), 64'd1);
        wr_byte(8'hFF, 1'b0);
        check("ff_ignored_level", 64'(level), 64'd4);
        wait_frames(fd0 + 5, 400);
        for (int i = 0; i < 4; i++) begin
            if (start_log.size() > i + 1)
                check($sformatf("gap_%0d", i), 64'(start_log[i+1] - start_log[i]), 64'd41);
            else
                check($sformatf("gap_%0d", i), 64'd0, 64'd41);
        end
        repeat (2) @(negedge clk);
        check("b2b_level_after", 64'(level), 64'd0);

        // Write coincident with a pop at level 2, pointers wrapping
        fd0 = frames_done;
        wr_byte(8'h10, 1'b1);
        wr_byte(8'h11, 1'b1);
        wr_byte(8'h12, 1'b1);
        t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("idle_level_before_pop", 64'(level), 64'd2);
        wr_byte(8'h13, 1'b1);
        check("coincident_level", 64'(level), 64'd2);
        check("coincident_busy", 64'(busy), 64'd1);
        wr_byte(8'h14, 1'b1);
        check("after_coincident_level", 64'(level), 64'd3);
        wait_frames(fd0 + 5, 400);
        repeat (2) @(negedge clk);
        check("wrap_level_after", 64'(level), 64'd0);

        // Reset during the 5th data bit of 0x3C with two bytes queued
        wr_byte(8'h3C, 1'b1);
        wr_byte(8'h3D, 1'b1);
        wr_byte(8'h3E, 1'b1);
        check("queued_level", 64'(level), 64'd2);
        repeat (20) @(negedge clk);
        check("pre_abort_txd_bit4", 64'(txd), 64'd1);
        rst = 1'b0;
        #1;
        check("abort_txd", 64'(txd), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_level", 64'(level), 64'd0);
        check("abort_full", 64'(full), 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        fd0 = frames_done;
        line_ok = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (!txd || busy) line_ok = 1'b0;
        end
        check("post_reset_idle_line", 64'(line_ok), 64'd1);
        check("post_reset_level", 64'(level), 64'd0);
        check("post_reset_no_frame", 64'(frames_done - fd0), 64'd0);

        // 0x00: 36 low samples then 4 high, checked by the monitor's waveform compare
        fd0 = frames_done;
        wr_byte(8'h00, 1'b1);
        wait_frames(fd0 + 1, 100);
        repeat (2) @(negedge clk);
        check("zero_busy_after", 64'(busy), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
